// File: rtl/arm_reg_bank.sv
// rtl/arm_reg_bank.sv - banked ARM7 register file with CPSR/SPSR store
// and a two-step exception-entry sequencer.
module arm_reg_bank #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] RESET_CPSR = 32'h0000_00D3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        read_en,
  input  logic [3:0]  read_reg,
  output logic [31:0] read_value,
  input  logic        write_en,
  input  logic [3:0]  write_reg,
  input  logic [31:0] write_value,
  input  logic        write_restore_from_SPSR,
  input  logic        mode_read_en,
  output logic [31:0] mode_read_value,
  input  logic        cpsr_read_en,
  output logic [31:0] cpsr_read_value,
  input  logic        cpsr_write_en,
  input  logic [31:0] cpsr_write_value,
  input  logic        exc_en,
  input  logic [4:0]  exc_mode,
  input  logic [31:0] exc_vector,
  input  logic [31:0] exc_return,
  output logic        exc_busy,
  output logic [31:0] pc_value
);

  typedef enum logic [1:0] {IDLE, SAVE, LINK} state_t;

  function automatic logic [2:0] mode_decode(input logic [4:0] m);
    case (m)
      5'h10:   return 3'd0;
      5'h1F:   return 3'd1;
      5'h11:   return 3'd2;
      5'h12:   return 3'd3;
      5'h13:   return 3'd4;
      5'h17:   return 3'd5;
      5'h1B:   return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  // gpr holds the user/system view of R0-R15; banked copies are indexed
  // by mode_code-2 (FIQ=0, IRQ=1, SVC=2, ABT=3, UND=4).
  logic [31:0] gpr      [0:15];
  logic [31:0] fiq_hi   [0:4];
  logic [31:0] r13_bank [0:4];
  logic [31:0] r14_bank [0:4];
  logic [31:0] spsr     [0:4];
  logic [31:0] cpsr;

  state_t      state;
  logic [4:0]  lat_mode;
  logic [31:0] lat_vector;
  logic [31:0] lat_return;

  logic [2:0]  cur_code, cur_idx, lat_code, lat_idx;
  logic        cur_banked, cur_fiq, lat_banked;
  logic [31:0] rd_data;

  assign cur_code   = mode_decode(cpsr[4:0]);
  assign cur_banked = (cur_code >= 3'd2) && (cur_code <= 3'd6);
  assign cur_fiq    = (cur_code == 3'd2);
  assign cur_idx    = cur_code - 3'd2;
  assign lat_code   = mode_decode(lat_mode);
  assign lat_banked = (lat_code >= 3'd2) && (lat_code <= 3'd6);
  assign lat_idx    = lat_code - 3'd2;

  assign exc_busy = (state != IDLE);
  assign pc_value = gpr[15];

  // R8-R12 map onto fiq_hi[0..4] through the low three index bits.
  always_comb begin
    rd_data = gpr[read_reg];
    if (read_reg == 4'd13 && cur_banked)
      rd_data = r13_bank[cur_idx];
    else if (read_reg == 4'd14 && cur_banked)
      rd_data = r14_bank[cur_idx];
    else if (cur_fiq && read_reg >= 4'd8 && read_reg <= 4'd12)
      rd_data = fiq_hi[read_reg[2:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      for (int i = 0; i < 5; i++) begin
        fiq_hi[i]   <= '0;
        r13_bank[i] <= '0;
        r14_bank[i] <= '0;
        spsr[i]     <= '0;
      end
      gpr[15]         <= RESET_PC;
      cpsr            <= RESET_CPSR;
      read_value      <= '0;
      mode_read_value <= '0;
      cpsr_read_value <= '0;
      state           <= IDLE;
      lat_mode        <= '0;
      lat_vector      <= '0;
      lat_return      <= '0;
    end else begin
      if (read_en)      read_value      <= rd_data;
      if (mode_read_en) mode_read_value <= {29'b0, cur_code};
      if (cpsr_read_en) cpsr_read_value <= cpsr;

      case (state)
        IDLE: begin
          if (write_en) begin
            if (write_reg == 4'd13 && cur_banked)
              r13_bank[cur_idx] <= write_value;
            else if (write_reg == 4'd14 && cur_banked)
              r14_bank[cur_idx] <= write_value;
            else if (cur_fiq && write_reg >= 4'd8 && write_reg <= 4'd12)
              fiq_hi[write_reg[2:0]] <= write_value;
            else
              gpr[write_reg] <= write_value;
          end
          // Restore from SPSR outranks a direct CPSR write on the same edge.
          if (write_en && write_restore_from_SPSR && cur_banked)
            cpsr <= spsr[cur_idx];
          else if (cpsr_write_en)
            cpsr <= cpsr_write_value;
          if (exc_en) begin
            lat_mode   <= exc_mode;
            lat_vector <= exc_vector;
            lat_return <= exc_return;
            state      <= SAVE;
          end
        end
        SAVE: begin
          if (lat_banked) spsr[lat_idx] <= cpsr;
          cpsr  <= {cpsr[31:8], 1'b1, cpsr[6] | (lat_code == 3'd2), cpsr[5], lat_mode};
          state <= LINK;
        end
        LINK: begin
          if (lat_banked) r14_bank[lat_idx] <= lat_return;
          else            gpr[14]           <= lat_return;
          gpr[15] <= lat_vector;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm_reg_bank.sv
// tb/tb_arm_reg_bank.sv - self-checking bench for arm_reg_bank against a
// flat physical-register model, with directed and random stimulus.
module tb_arm_reg_bank;

  logic        clk = 0;
  logic        rst = 1;
  logic        read_en = 0;
  logic [3:0]  read_reg = 0;
  logic [31:0] read_value;
  logic        write_en = 0;
  logic [3:0]  write_reg = 0;
  logic [31:0] write_value = 0;
  logic        write_restore_from_SPSR = 0;
  logic        mode_read_en = 0;
  logic [31:0] mode_read_value;
  logic        cpsr_read_en = 0;
  logic [31:0] cpsr_read_value;
  logic        cpsr_write_en = 0;
  logic [31:0] cpsr_write_value = 0;
  logic        exc_en = 0;
  logic [4:0]  exc_mode = 0;
  logic [31:0] exc_vector = 0;
  logic [31:0] exc_return = 0;
  logic        exc_busy;
  logic [31:0] pc_value;

  arm_reg_bank dut (
    .clk(clk), .rst(rst),
    .read_en(read_en), .read_reg(read_reg), .read_value(read_value),
    .write_en(write_en), .write_reg(write_reg), .write_value(write_value),
    .write_restore_from_SPSR(write_restore_from_SPSR),
    .mode_read_en(mode_read_en), .mode_read_value(mode_read_value),
    .cpsr_read_en(cpsr_read_en), .cpsr_read_value(cpsr_read_value),
    .cpsr_write_en(cpsr_write_en), .cpsr_write_value(cpsr_write_value),
    .exc_en(exc_en), .exc_mode(exc_mode), .exc_vector(exc_vector),
    .exc_return(exc_return), .exc_busy(exc_busy), .pc_value(pc_value)
  );

  always #5 clk = ~clk;

  int n_run = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Model: every architectural register slot lives in one flat array.
  // 0-15 user view (15 = PC), 16-20 FIQ R8-R12, 24+2k / 25+2k R13/R14 of bank k.
  logic [31:0] m_reg [0:47];
  logic [31:0] m_spsr [0:7];
  logic [31:0] m_cpsr, m_read, m_mode_read, m_cpsr_read;
  logic [4:0]  m_lat_mode;
  logic [31:0] m_lat_vec, m_lat_ret;
  int          m_step;

  function automatic int mcode(input logic [4:0] m);
    case (m)
      5'h10: return 0;
      5'h1F: return 1;
      5'h11: return 2;
      5'h12: return 3;
      5'h13: return 4;
      5'h17: return 5;
      5'h1B: return 6;
      default: return 7;
    endcase
  endfunction

  function automatic int phys(input int code, input int r);
    if (r >= 8 && r <= 12 && code == 2) return 16 + r - 8;
    if ((r == 13 || r == 14) && code >= 2 && code <= 6) return 24 + (code - 2) * 2 + (r - 13);
    return r;
  endfunction

  always @(posedge clk) begin
    int code, tcode;
    if (rst) begin
      for (int i = 0; i < 48; i++) m_reg[i] = 0;
      for (int i = 0; i < 8; i++) m_spsr[i] = 0;
      m_cpsr = 32'hD3;
      m_read = 0; m_mode_read = 0; m_cpsr_read = 0;
      m_step = 0;
    end else begin
      code = mcode(m_cpsr[4:0]);
      if (read_en)      m_read      = m_reg[phys(code, int'(read_reg))];
      if (mode_read_en) m_mode_read = code;
      if (cpsr_read_en) m_cpsr_read = m_cpsr;
      if (m_step == 0) begin
        if (write_en) m_reg[phys(code, int'(write_reg))] = write_value;
        if (write_en && write_restore_from_SPSR && code >= 2 && code <= 6)
          m_cpsr = m_spsr[code];
        else if (cpsr_write_en)
          m_cpsr = cpsr_write_value;
        if (exc_en) begin
          m_lat_mode = exc_mode; m_lat_vec = exc_vector; m_lat_ret = exc_return;
          m_step = 1;
        end
      end else if (m_step == 1) begin
        tcode = mcode(m_lat_mode);
        if (tcode >= 2 && tcode <= 6) m_spsr[tcode] = m_cpsr;
        m_cpsr[4:0] = m_lat_mode;
        m_cpsr[7] = 1'b1;
        if (tcode == 2) m_cpsr[6] = 1'b1;
        m_step = 2;
      end else begin
        tcode = mcode(m_lat_mode);
        m_reg[phys(tcode, 14)] = m_lat_ret;
        m_reg[15] = m_lat_vec;
        m_step = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("cmp_read_value", read_value, m_read);
      check("cmp_mode_read_value", mode_read_value, m_mode_read);
      check("cmp_cpsr_read_value", cpsr_read_value, m_cpsr_read);
      check("cmp_exc_busy", {31'b0, exc_busy}, {31'b0, m_step != 0});
      check("cmp_pc_value", pc_value, m_reg[15]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    read_en = 0; mode_read_en = 0; cpsr_read_en = 0;
    write_en = 0; write_restore_from_SPSR = 0; cpsr_write_en = 0; exc_en = 0;
  endtask

  task automatic wr(input logic [3:0] r, input logic [31:0] v, input logic restore);
    write_en = 1; write_reg = r; write_value = v; write_restore_from_SPSR = restore;
    cyc();
  endtask

  task automatic set_cpsr(input logic [31:0] v);
    cpsr_write_en = 1; cpsr_write_value = v;
    cyc();
  endtask

  task automatic rd(input logic [3:0] r, output logic [31:0] v);
    read_en = 1; read_reg = r;
    cyc();
    v = read_value;
  endtask

  task automatic rd_cpsr(output logic [31:0] v);
    cpsr_read_en = 1;
    cyc();
    v = cpsr_read_value;
  endtask

  task automatic rd_mode(output logic [31:0] v);
    mode_read_en = 1;
    cyc();
    v = mode_read_value;
  endtask

  task automatic exc(input logic [4:0] m, input logic [31:0] vec, input logic [31:0] ret);
    exc_en = 1; exc_mode = m; exc_vector = vec; exc_return = ret;
    cyc();
  endtask

  logic [4:0] mode_tab [0:7];
  initial begin
    logic [31:0] v, r32;
    mode_tab = '{5'h10, 5'h1F, 5'h11, 5'h12, 5'h13, 5'h17, 5'h1B, 5'h05};
    rst = 1;
    @(posedge clk); @(posedge clk); @(negedge clk);
    rst = 0;
    chk_on = 1;

    check("reset_read_value", read_value, 32'h0);
    check("reset_exc_busy", {31'b0, exc_busy}, 32'h0);
    check("reset_pc", pc_value, 32'h0);
    rd_cpsr(v);  check("t1_cpsr", v, 32'h0000_00D3);
    rd_mode(v);  check("t1_mode", v, 32'd4);
    rd(4'd15, v); check("t1_r15", v, 32'h0);

    wr(4'd13, 32'h1111, 0);
    set_cpsr(32'h10);
    wr(4'd13, 32'h2222, 0);
    rd(4'd13, v); check("t2_r13_usr", v, 32'h2222);
    set_cpsr(32'h13);
    rd(4'd13, v); check("t2_r13_svc", v, 32'h1111);

    set_cpsr(32'h11);
    wr(4'd8, 32'hAA, 0);
    set_cpsr(32'h10);
    rd(4'd8, v); check("t3_r8_usr", v, 32'h0);
    wr(4'd7, 32'h77, 0);
    set_cpsr(32'h11);
    rd(4'd8, v); check("t3_r8_fiq", v, 32'hAA);
    rd(4'd7, v); check("t3_r7_fiq", v, 32'h77);

    set_cpsr(32'hF000_0010);
    exc(5'h12, 32'h18, 32'h104);
    check("t4_busy_save", {31'b0, exc_busy}, 32'h1);
    write_en = 1; write_reg = 4'd0; write_value = 32'hDEAD;
    cyc();
    check("t4_busy_link", {31'b0, exc_busy}, 32'h1);
    write_en = 1; write_reg = 4'd0; write_value = 32'hDEAD;
    cpsr_write_en = 1; cpsr_write_value = 32'h1F;
    cyc();
    check("t4_busy_done", {31'b0, exc_busy}, 32'h0);
    check("t4_pc", pc_value, 32'h18);
    rd_cpsr(v);   check("t4_cpsr", v, 32'hF000_0092);
    rd(4'd14, v); check("t4_r14_irq", v, 32'h104);
    rd(4'd0, v);  check("t4_r0_dropped", v, 32'h0);

    wr(4'd15, 32'h104, 1);
    check("t5_pc", pc_value, 32'h104);
    rd_cpsr(v); check("t5_cpsr_restored", v, 32'hF000_0010);
    rd_mode(v); check("t5_mode", v, 32'd0);
    wr(4'd1, 32'h5, 1);
    rd_cpsr(v); check("t5_usr_restore_ignored", v, 32'hF000_0010);
    rd(4'd1, v); check("t5_usr_write", v, 32'h5);

    set_cpsr(32'h12);
    write_en = 1; write_reg = 4'd2; write_value = 32'h3; write_restore_from_SPSR = 1;
    cpsr_write_en = 1; cpsr_write_value = 32'hDEAD_0013;
    cyc();
    rd_cpsr(v); check("t6_restore_priority", v, 32'hF000_0010);
    exc(5'h12, 32'h18, 32'h104);
    rst = 1;
    cyc();
    rst = 0;
    check("t6_rst_busy", {31'b0, exc_busy}, 32'h0);
    rd_cpsr(v); check("t6_rst_cpsr", v, 32'h0000_00D3);
    check("t6_rst_pc", pc_value, 32'h0);
    set_cpsr(32'h12);
    wr(4'd0, 32'h0, 1);
    rd_cpsr(v); check("t6_spsr_irq_cleared", v, 32'h0);

    for (int n = 0; n < 3000; n++) begin
      read_en      = ($urandom_range(0, 1) == 1);
      read_reg     = 4'($urandom_range(0, 15));
      mode_read_en = ($urandom_range(0, 2) == 0);
      cpsr_read_en = ($urandom_range(0, 2) == 0);
      write_en     = ($urandom_range(0, 4) < 2);
      write_reg    = 4'($urandom_range(0, 15));
      write_value  = $urandom();
      write_restore_from_SPSR = ($urandom_range(0, 4) == 0);
      cpsr_write_en = ($urandom_range(0, 9) == 0);
      r32 = $urandom();
      cpsr_write_value = {r32[31:5], mode_tab[$urandom_range(0, 7)]};
      exc_en     = ($urandom_range(0, 19) == 0);
      exc_mode   = mode_tab[$urandom_range(0, 7)];
      exc_vector = $urandom();
      exc_return = $urandom();
      rst        = ($urandom_range(0, 99) == 0);
      @(posedge clk);
      @(negedge clk);
    end
    rst = 0;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
